// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and elaboration-time helpers for the BCD up/down counter.
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } step_state_e;

   localparam int unsigned MAX_DIGITS = 4;

   // Segment patterns for BCD codes 0..9; bits 8 and 7 are never lit.
   localparam logic [8:0] SEG_TABLE [10] = '{
      9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
      9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
   };

   function automatic int unsigned cnt_width(input int unsigned modulus);
      return $clog2(modulus);
   endfunction

   function automatic int unsigned timer_width(input int unsigned hold, input int unsigned rep);
      int unsigned m;
      m = (hold > rep) ? hold : rep;
      return $clog2(m);
   endfunction

   function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int unsigned value,
                                                      input int unsigned digits);
      logic [4*MAX_DIGITS-1:0] r;
      int unsigned v;
      r = '0;
      v = value;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
         end
      end
      return r;
   endfunction

   function automatic logic [8:0] seg_decode(input logic [3:0] code);
      return (code <= 4'd9) ? SEG_TABLE[code] : 9'h000;
   endfunction

endpackage

// File: rtl/step_repeat_gen.sv
// Turns debounced button levels into single-cycle step pulses, with optional
// hold-to-auto-repeat after an initial delay.
module step_repeat_gen
   import bcd_counter_pkg::*;
#(
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc_lvl,
   input  logic dec_lvl,
   output logic step_up,
   output logic step_dn
);

   localparam int unsigned     TMR_W     = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

   step_state_e      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             dir_up_q, dir_up_d;
   logic             prev_inc_q, prev_dec_q;
   logic             armed_q;
   logic             rise_inc, rise_dec, abort;

   always_comb begin
      // armed_q masks the first cycle after reset so a held button cannot fake a rise
      rise_inc = armed_q & inc_lvl & ~prev_inc_q;
      rise_dec = armed_q & dec_lvl & ~prev_dec_q;
      abort    = dir_up_q ? (~inc_lvl | dec_lvl) : (~dec_lvl | inc_lvl);
      state_d  = state_q;
      timer_d  = timer_q;
      dir_up_d = dir_up_q;
      step_up  = 1'b0;
      step_dn  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_inc && !dec_lvl) begin
               step_up  = 1'b1;
               dir_up_d = 1'b1;
               if (REPEAT_EN) begin
                  state_d = HOLD;
                  timer_d = '0;
               end
            end else if (rise_dec && !inc_lvl) begin
               step_dn  = 1'b1;
               dir_up_d = 1'b0;
               if (REPEAT_EN) begin
                  state_d = HOLD;
                  timer_d = '0;
               end
            end
         end
         HOLD: begin
            if (abort) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == HOLD_LAST) begin
               step_up = dir_up_q;
               step_dn = ~dir_up_q;
               state_d = REPEAT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         REPEAT: begin
            if (abort) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == REP_LAST) begin
               step_up = dir_up_q;
               step_dn = ~dir_up_q;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
      if (clr) begin
         state_d = IDLE;
         timer_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         dir_up_q   <= 1'b0;
         prev_inc_q <= 1'b0;
         prev_dec_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         dir_up_q   <= dir_up_d;
         prev_inc_q <= inc_lvl;
         prev_dec_q <= dec_lvl;
         armed_q    <= 1'b1;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with wrap/saturate, auto-repeat buttons and
// registered seven-segment outputs that always track the count.
module bcd_updown_counter
   import bcd_counter_pkg::*;
#(
   parameter int unsigned DIGITS        = 2,
   parameter int unsigned MODULUS       = 20,
   parameter bit          WRAP          = 1'b1,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                inc_lvl,
   input  logic                                dec_lvl,
   input  logic                                clr,
   output logic [cnt_width(MODULUS)-1:0]       count,
   output logic [4*DIGITS-1:0]                 bcd,
   output logic [9*DIGITS-1:0]                 seg_led,
   output logic                                at_max,
   output logic                                at_min,
   output logic                                wrapped
);

   localparam int unsigned      CNT_W   = cnt_width(MODULUS);
   localparam int unsigned      BCD_W   = 4 * DIGITS;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);
   localparam logic [BCD_W-1:0] MAX_BCD = BCD_W'(to_bcd(MODULUS - 1, DIGITS));

   logic                 step_up, step_dn;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [9*DIGITS-1:0]  seg_q, seg_d;
   logic                 at_max_q, at_max_d;
   logic                 at_min_q, at_min_d;
   logic                 wrapped_q, wrapped_d;

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      logic             carry;
      r     = b;
      carry = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (b[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = b[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      logic             borrow;
      r      = b;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (b[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = b[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   step_repeat_gen #(
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_step (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .inc_lvl (inc_lvl),
      .dec_lvl (dec_lvl),
      .step_up (step_up),
      .step_dn (step_dn)
   );

   always_comb begin
      count_d   = count_q;
      bcd_d     = bcd_q;
      wrapped_d = 1'b0;
      if (clr) begin
         count_d = '0;
         bcd_d   = '0;
      end else if (step_up) begin
         if (count_q == MAX_CNT) begin
            if (WRAP) begin
               count_d   = '0;
               bcd_d     = '0;
               wrapped_d = 1'b1;
            end
         end else begin
            count_d = count_q + CNT_W'(1);
            bcd_d   = bcd_inc(bcd_q);
         end
      end else if (step_dn) begin
         if (count_q == '0) begin
            if (WRAP) begin
               count_d   = MAX_CNT;
               bcd_d     = MAX_BCD;
               wrapped_d = 1'b1;
            end
         end else begin
            count_d = count_q - CNT_W'(1);
            bcd_d   = bcd_dec(bcd_q);
         end
      end
      // Decode from next-state values so the display never lags the count
      for (int unsigned i = 0; i < DIGITS; i++) begin
         seg_d[9*i +: 9] = seg_decode(bcd_d[4*i +: 4]);
      end
      at_max_d = (count_d == MAX_CNT);
      at_min_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         bcd_q     <= '0;
         seg_q     <= {DIGITS{9'h03f}};
         at_max_q  <= 1'b0;
         at_min_q  <= 1'b1;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         bcd_q     <= bcd_d;
         seg_q     <= seg_d;
         at_max_q  <= at_max_d;
         at_min_q  <= at_min_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign count   = count_q;
   assign bcd     = bcd_q;
   assign seg_led = seg_q;
   assign at_max  = at_max_q;
   assign at_min  = at_min_q;
   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: four counter variants share one button stimulus and are
// compared every cycle against a time-since-press reference model.
module tb_bcd_updown_counter;

   localparam int H = 8;
   localparam int R = 4;
   localparam int P_MOD  [4] = '{20, 20, 20, 250};
   localparam int P_DIG  [4] = '{2, 2, 2, 3};
   localparam bit P_WRAP [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   localparam bit P_REP  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

   logic clk = 1'b0;
   logic rst = 1'b1, inc = 1'b0, dec = 1'b0, clr = 1'b0;

   logic [4:0]  c0, c1, c2;
   logic [7:0]  c3;
   logic [7:0]  b0, b1, b2;
   logic [11:0] b3;
   logic [17:0] s0, s1, s2;
   logic [26:0] s3;
   logic [3:0]  amax, amin, wr;
   logic [31:0] cnt_a [4];
   logic [31:0] bcd_a [4];
   logic [31:0] seg_a [4];

   assign cnt_a[0] = 32'(c0);
   assign cnt_a[1] = 32'(c1);
   assign cnt_a[2] = 32'(c2);
   assign cnt_a[3] = 32'(c3);
   assign bcd_a[0] = 32'(b0);
   assign bcd_a[1] = 32'(b1);
   assign bcd_a[2] = 32'(b2);
   assign bcd_a[3] = 32'(b3);
   assign seg_a[0] = 32'(s0);
   assign seg_a[1] = 32'(s1);
   assign seg_a[2] = 32'(s2);
   assign seg_a[3] = 32'(s3);

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(2), .MODULUS(20), .WRAP(1'b1), .REPEAT_EN(1'b1),
                        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut0 (
      .clk(clk), .rst(rst), .inc_lvl(inc), .dec_lvl(dec), .clr(clr),
      .count(c0), .bcd(b0), .seg_led(s0), .at_max(amax[0]), .at_min(amin[0]), .wrapped(wr[0]));
   bcd_updown_counter #(.DIGITS(2), .MODULUS(20), .WRAP(1'b0), .REPEAT_EN(1'b1),
                        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut1 (
      .clk(clk), .rst(rst), .inc_lvl(inc), .dec_lvl(dec), .clr(clr),
      .count(c1), .bcd(b1), .seg_led(s1), .at_max(amax[1]), .at_min(amin[1]), .wrapped(wr[1]));
   bcd_updown_counter #(.DIGITS(2), .MODULUS(20), .WRAP(1'b1), .REPEAT_EN(1'b0),
                        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut2 (
      .clk(clk), .rst(rst), .inc_lvl(inc), .dec_lvl(dec), .clr(clr),
      .count(c2), .bcd(b2), .seg_led(s2), .at_max(amax[2]), .at_min(amin[2]), .wrapped(wr[2]));
   bcd_updown_counter #(.DIGITS(3), .MODULUS(250), .WRAP(1'b1), .REPEAT_EN(1'b1),
                        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut3 (
      .clk(clk), .rst(rst), .inc_lvl(inc), .dec_lvl(dec), .clr(clr),
      .count(c3), .bcd(b3), .seg_led(s3), .at_max(amax[3]), .at_min(amin[3]), .wrapped(wr[3]));

   typedef struct {
      int inst;
      int cnt;
      int bcd;
      int seg;
      bit amax;
      bit amin;
      bit wr;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference state: count as an integer, button activity as age since press.
   int m_cnt [4];
   bit m_act [4];
   int m_age [4];
   bit m_up  [4];
   bit m_wr  [4];
   bit p_inc = 1'b0, p_dec = 1'b0, m_armed = 1'b0;

   function automatic int seg_ref(input int d);
      case (d)
         0: return 'h03f;
         1: return 'h006;
         2: return 'h05b;
         3: return 'h04f;
         4: return 'h066;
         5: return 'h06d;
         6: return 'h07d;
         7: return 'h007;
         8: return 'h07f;
         9: return 'h06f;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_bcd(input int v, input int dig);
      int r = 0;
      int x = v;
      for (int k = 0; k < dig; k++) begin
         r = r | ((x % 10) << (4 * k));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int exp_seg(input int v, input int dig);
      int r = 0;
      int x = v;
      for (int k = 0; k < dig; k++) begin
         r = r | (seg_ref(x % 10) << (9 * k));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_step();
      exp_t e;
      int   stp;
      for (int i = 0; i < 4; i++) begin
         stp     = 0;
         m_wr[i] = 1'b0;
         if (rst) begin
            m_cnt[i] = 0;
            m_act[i] = 1'b0;
         end else begin
            if (m_act[i]) begin
               if (m_up[i] ? (!inc || dec) : (!dec || inc)) begin
                  m_act[i] = 1'b0;
               end else begin
                  m_age[i]++;
                  if (m_age[i] == H || (m_age[i] > H && (m_age[i] - H) % R == 0))
                     stp = m_up[i] ? 1 : -1;
               end
            end else if (m_armed && inc && !p_inc && !dec) begin
               stp = 1;
               if (P_REP[i]) begin m_act[i] = 1'b1; m_age[i] = 0; m_up[i] = 1'b1; end
            end else if (m_armed && dec && !p_dec && !inc) begin
               stp = -1;
               if (P_REP[i]) begin m_act[i] = 1'b1; m_age[i] = 0; m_up[i] = 1'b0; end
            end
            if (clr) begin
               m_cnt[i] = 0;
               m_act[i] = 1'b0;
            end else if (stp == 1) begin
               if (m_cnt[i] < P_MOD[i] - 1) m_cnt[i]++;
               else if (P_WRAP[i]) begin m_cnt[i] = 0; m_wr[i] = 1'b1; end
            end else if (stp == -1) begin
               if (m_cnt[i] > 0) m_cnt[i]--;
               else if (P_WRAP[i]) begin m_cnt[i] = P_MOD[i] - 1; m_wr[i] = 1'b1; end
            end
         end
         e.inst = i;
         e.cnt  = m_cnt[i];
         e.bcd  = exp_bcd(m_cnt[i], P_DIG[i]);
         e.seg  = exp_seg(m_cnt[i], P_DIG[i]);
         e.amax = (m_cnt[i] == P_MOD[i] - 1);
         e.amin = (m_cnt[i] == 0);
         e.wr   = m_wr[i];
         sb.push_back(e);
      end
      if (rst) begin
         p_inc = 1'b0; p_dec = 1'b0; m_armed = 1'b0;
      end else begin
         p_inc = inc; p_dec = dec; m_armed = 1'b1;
      end
   endtask

   // Monitor: every output cycle, pop and compare all queued expectations.
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e  = sb.pop_front();
            ok = 1'b1;
            n_vec++;
            if (cnt_a[e.inst] != 32'(e.cnt)) begin
               $display("FAIL count[%0d] got %0d want %0d", e.inst, cnt_a[e.inst], e.cnt); ok = 1'b0;
            end
            if (bcd_a[e.inst] != 32'(e.bcd)) begin
               $display("FAIL bcd[%0d] got %h want %h", e.inst, bcd_a[e.inst], e.bcd); ok = 1'b0;
            end
            if (seg_a[e.inst] != 32'(e.seg)) begin
               $display("FAIL seg_led[%0d] got %h want %h", e.inst, seg_a[e.inst], e.seg); ok = 1'b0;
            end
            if (amax[e.inst] != e.amax || amin[e.inst] != e.amin) begin
               $display("FAIL limits[%0d] got max=%0b min=%0b want max=%0b min=%0b",
                        e.inst, amax[e.inst], amin[e.inst], e.amax, e.amin); ok = 1'b0;
            end
            if (wr[e.inst] != e.wr) begin
               $display("FAIL wrapped[%0d] got %0b want %0b", e.inst, wr[e.inst], e.wr); ok = 1'b0;
            end
            if (!ok) n_err++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         $display("FAIL %s got %h want %h", name, got, want);
         n_err++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic press(input bit up);
      if (up) inc = 1'b1; else dec = 1'b1;
      cycle(); cycle();
      inc = 1'b0; dec = 1'b0;
      cycle(); cycle();
   endtask

   task automatic do_clr();
      clr = 1'b1; cycle();
      clr = 1'b0; cycle();
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0; m_act[i] = 1'b0; m_age[i] = 0; m_up[i] = 1'b0; m_wr[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) cycle();
      chk("rst_count", cnt_a[0], 32'd0);
      chk("rst_seg", seg_a[0], 32'h7e3f);
      chk("rst_seg3", seg_a[3], 32'hfc7e3f);
      chk("rst_flags", {29'd0, amin[0], amax[0], wr[0]}, 32'h4);
      rst = 1'b0;
      cycle(); cycle();

      repeat (19) press(1'b1);
      chk("nineteen_count", cnt_a[0], 32'd19);
      chk("nineteen_bcd", bcd_a[0], 32'h19);
      chk("nineteen_seg", seg_a[0], 32'hc6f);
      chk("nineteen_max", {31'd0, amax[0]}, 32'd1);
      inc = 1'b1; cycle();
      chk("wrap_up_count", cnt_a[0], 32'd0);
      chk("wrap_up_pulse", {31'd0, wr[0]}, 32'd1);
      chk("sat_up_count", cnt_a[1], 32'd19);
      cycle();
      chk("wrap_up_pulse_end", {31'd0, wr[0]}, 32'd0);
      inc = 1'b0; cycle(); cycle();

      do_clr();
      dec = 1'b1; cycle();
      chk("wrap_dn_count", cnt_a[0], 32'd19);
      chk("wrap_dn_bcd", bcd_a[0], 32'h19);
      chk("wrap_dn_pulse", {31'd0, wr[0]}, 32'd1);
      chk("sat_dn_count", cnt_a[1], 32'd0);
      chk("sat_dn_pulse", {31'd0, wr[1]}, 32'd0);
      dec = 1'b0; cycle(); cycle();

      do_clr();
      repeat (5) press(1'b1);
      inc = 1'b1;
      repeat (20) cycle();
      inc = 1'b0; cycle();
      chk("hold_repeat_count", cnt_a[0], 32'd9);
      chk("no_repeat_count", cnt_a[2], 32'd6);
      cycle();
      press(1'b1);
      chk("carry_count", cnt_a[0], 32'd10);
      chk("carry_bcd", bcd_a[0], 32'h10);
      chk("carry_seg", seg_a[0], 32'hc3f);

      inc = 1'b1; dec = 1'b1; cycle();
      chk("both_rise", cnt_a[0], 32'd10);
      inc = 1'b0; dec = 1'b0; cycle(); cycle();
      inc = 1'b1; cycle(); cycle(); cycle();
      dec = 1'b1; cycle(); cycle(); cycle();
      inc = 1'b0; dec = 1'b0;
      repeat (12) cycle();
      chk("opposite_abort", cnt_a[0], 32'd11);

      do_clr();
      repeat (7) press(1'b1);
      inc = 1'b1; clr = 1'b1; cycle();
      chk("clr_beats_step_cnt", cnt_a[0], 32'd0);
      chk("clr_beats_step_bcd", bcd_a[0], 32'd0);
      inc = 1'b0; clr = 1'b0; cycle(); cycle();

      inc = 1'b1;
      repeat (15) cycle();
      rst = 1'b1; cycle(); cycle();
      rst = 1'b0;
      repeat (20) cycle();
      chk("held_after_rst_cnt", cnt_a[0], 32'd0);
      chk("held_after_rst_seg", seg_a[0], 32'h7e3f);
      inc = 1'b0; cycle(); cycle();
      press(1'b1);
      chk("repress_after_rst", cnt_a[0], 32'd1);

      do_clr();
      inc = 1'b1;
      repeat (40) cycle();
      inc = 1'b0; cycle(); cycle();
      chk("single_step_no_repeat", cnt_a[2], 32'd1);

      do_clr();
      inc = 1'b1;
      guard = 0;
      while (m_cnt[3] != 100 && guard < 1000) begin
         cycle();
         guard++;
      end
      inc = 1'b0; cycle(); cycle();
      chk("three_digit_100", bcd_a[3], 32'h100);
      press(1'b0);
      chk("three_digit_borrow", bcd_a[3], 32'h099);

      repeat (3000) begin
         if ($urandom_range(0, 7) == 0)   inc = ~inc;
         if ($urandom_range(0, 11) == 0)  dec = ~dec;
         clr = ($urandom_range(0, 59) == 0);
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 1'b0; clr = 1'b0; inc = 1'b0; dec = 1'b0;
      cycle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
